// File: rtl/man_norm.sv
// Mantissa normalizer between the mantissa ALU and the rounding stage.
// It applies carry-out correction, detects zero and subnormal results, and left-shifts one bit per cycle.
module man_norm #(
    parameter int SIZE_MAN = 28,
    parameter int SIZE_EXP = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sign,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic [SIZE_MAN-1:0] i_man,
    input  logic                i_overflow,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sign,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic [SIZE_MAN-1:0] o_man,
    output logic                o_zero,
    output logic                o_denorm,
    output logic                o_inf
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    localparam logic [SIZE_EXP-1:0] EXP_MAX = '1;

    state_t              r_state, w_next;
    logic                r_sign, r_ovf;
    logic [SIZE_EXP-1:0] r_exp;
    logic [SIZE_MAN-1:0] r_man;

    logic                w_accept;
    logic [SIZE_EXP-1:0] w_exp_inc;
    logic                w_exp_lo;
    logic                w_stop;

    assign o_ready   = (r_state == IDLE) && i_rst_n;
    assign o_valid   = (r_state == DONE);
    assign w_accept  = i_valid && o_ready;
    assign w_exp_inc = r_exp + SIZE_EXP'(1);
    // An exponent of 0 or 1 leaves no room for another shift; treat both as the subnormal boundary.
    assign w_exp_lo  = (r_exp[SIZE_EXP-1:1] == '0);
    assign w_stop    = (r_exp == EXP_MAX) || r_ovf || (r_man == '0) ||
                       r_man[SIZE_MAN-1] || w_exp_lo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = NORM;
            NORM:    if (w_stop)   w_next = DONE;
            DONE:    if (i_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_exp    <= '0;
            r_man    <= '0;
            o_sign   <= 1'b0;
            o_exp    <= '0;
            o_man    <= '0;
            o_zero   <= 1'b0;
            o_denorm <= 1'b0;
            o_inf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_accept) begin
                r_sign <= i_sign;
                r_exp  <= i_exp;
                r_man  <= i_man;
                r_ovf  <= i_overflow;
            end else if (r_state == NORM && !w_stop) begin
                r_man <= {r_man[SIZE_MAN-2:0], 1'b0};
                r_exp <= r_exp - SIZE_EXP'(1);
            end
            // Outputs and flags change only on the edge that enters DONE.
            if (r_state == NORM && w_stop) begin
                o_sign   <= r_sign;
                o_exp    <= r_exp;
                o_man    <= r_man;
                o_zero   <= 1'b0;
                o_denorm <= 1'b0;
                o_inf    <= 1'b0;
                if (r_exp == EXP_MAX) begin
                    // Inf/NaN input: pass through untouched.
                end else if (r_ovf) begin
                    if (w_exp_inc == EXP_MAX) begin
                        o_exp <= EXP_MAX;
                        o_man <= '0;
                        o_inf <= 1'b1;
                    end else begin
                        o_exp <= w_exp_inc;
                        o_man <= {1'b1, r_man[SIZE_MAN-1:2], r_man[1] | r_man[0]};
                    end
                end else if (r_man == '0) begin
                    o_exp  <= '0;
                    o_zero <= 1'b1;
                end else if (!r_man[SIZE_MAN-1]) begin
                    o_exp    <= '0;
                    o_denorm <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_man_norm.sv
// Table-driven bench for man_norm: an expectation is queued at each accept and checked when o_valid rises.
// Hand sequences cover the DONE stall, the no-same-cycle accept rule, and reset in NORM and DONE.
module tb_man_norm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_sign, i_overflow, i_ready;
    logic [7:0]  i_exp;
    logic [27:0] i_man;
    logic        o_ready, o_valid, o_sign, o_zero, o_denorm, o_inf;
    logic [7:0]  o_exp;
    logic [27:0] o_man;

    always #5 clk = ~clk;

    man_norm #(.SIZE_MAN(28), .SIZE_EXP(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .i_overflow(i_overflow),
        .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp),
        .o_man(o_man), .o_zero(o_zero), .o_denorm(o_denorm), .o_inf(o_inf)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] man;
        logic        ovf;
        logic        e_sign;
        logic [7:0]  e_exp;
        logic [27:0] e_man;
        logic [2:0]  e_flags;  // {zero, denorm, inf}
        int          e_lat;
    } vec_t;

    vec_t tbl[11];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic s, logic [7:0] e, logic [27:0] m, logic ov,
                                logic [7:0] ee, logic [27:0] em, logic [2:0] ef, int lat);
        vec_t v;
        v.sign = s; v.exp = e; v.man = m; v.ovf = ov;
        v.e_sign = s; v.e_exp = ee; v.e_man = em; v.e_flags = ef; v.e_lat = lat;
        return v;
    endfunction

    // Drive one input, queue its expectation at the accept edge, and wait for o_valid.
    // The result is left in DONE with i_ready low.
    task automatic issue(input vec_t v, output int lat);
        @(negedge clk);
        i_valid = 1'b1; i_sign = v.sign; i_exp = v.exp; i_man = v.man; i_overflow = v.ovf;
        i_ready = 1'b0;
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic compare(input int lat);
        vec_t e;
        n_vec++;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("o_valid", {31'd0, o_valid}, 32'd1);
        chk("latency", lat, e.e_lat);
        chk("o_sign", {31'd0, o_sign}, {31'd0, e.e_sign});
        chk("o_exp", {24'd0, o_exp}, {24'd0, e.e_exp});
        chk("o_man", {4'd0, o_man}, {4'd0, e.e_man});
        chk("flags", {29'd0, o_zero, o_denorm, o_inf}, {29'd0, e.e_flags});
        chk("o_ready_in_done", {31'd0, o_ready}, 32'd0);
    endtask

    task automatic release_done();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("back_to_idle", {30'd0, o_valid, o_ready}, 32'b01);
    endtask

    initial begin
        int          lat;
        logic [27:0] hold_man;
        logic [7:0]  hold_exp;

        tbl[0]  = mk(0, 8'd100, 28'h8000000, 0, 8'd100, 28'h8000000, 3'b000, 2);
        tbl[1]  = mk(1, 8'd100, 28'h0000003, 1, 8'd101, 28'h8000001, 3'b000, 2);
        tbl[2]  = mk(0, 8'd254, 28'h0000003, 1, 8'd255, 28'h0000000, 3'b001, 2);
        tbl[3]  = mk(1, 8'd100, 28'h0100000, 0, 8'd93,  28'h8000000, 3'b000, 9);
        tbl[4]  = mk(0, 8'd5,   28'h0000010, 0, 8'd0,   28'h0000100, 3'b010, 6);
        tbl[5]  = mk(1, 8'd77,  28'h0000000, 0, 8'd0,   28'h0000000, 3'b100, 2);
        tbl[6]  = mk(1, 8'd255, 28'h0000001, 1, 8'd255, 28'h0000001, 3'b000, 2);
        tbl[7]  = mk(0, 8'd1,   28'h4000000, 0, 8'd0,   28'h4000000, 3'b010, 2);
        tbl[8]  = mk(0, 8'd200, 28'h0000001, 0, 8'd173, 28'h8000000, 3'b000, 29);
        tbl[9]  = mk(1, 8'd10,  28'hFFFFFFF, 1, 8'd11,  28'hFFFFFFF, 3'b000, 2);
        tbl[10] = mk(0, 8'd3,   28'h0000005, 1, 8'd4,   28'h8000003, 3'b000, 2);

        rst_n = 1'b0; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_man = '0;
        i_overflow = 1'b0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {o_valid, o_ready, o_sign, o_exp, o_man[19:0], o_zero, o_denorm, o_inf}, 32'd0);
        chk("reset_man", {4'd0, o_man}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {30'd0, o_valid, o_ready}, 32'b01);

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i], lat);
            compare(lat);
            release_done();
        end

        // Stall in DONE for 5 cycles with i_valid held high; nothing may move.
        issue(tbl[3], lat);
        compare(lat);
        hold_man = o_man; hold_exp = o_exp;
        i_valid = 1'b1; i_man = 28'h0000001; i_exp = 8'd50;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            chk("stall_hold", {o_valid, o_ready, 2'b00, o_exp, hold_exp, 4'd0, o_man[7:0]},
                {2'b10, 2'b00, hold_exp, hold_exp, 4'd0, hold_man[7:0]});
        end
        // i_ready=1 in DONE with i_valid high: no capture on that edge.
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0; i_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        chk("no_accept_in_done", {30'd0, o_valid, o_ready}, 32'b01);

        // Reset mid-NORM, with a new input presented during reset.
        @(negedge clk);
        i_valid = 1'b1; i_man = 28'h0000001; i_exp = 8'd200; i_overflow = 1'b0; i_sign = 1'b1;
        @(negedge clk);
        i_man = 28'h8000000; i_exp = 8'd9;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("reset_mid_norm", {o_valid, o_ready, o_sign, o_exp, o_zero, o_denorm, o_inf, 19'd0}, 32'd0);
        chk("reset_mid_norm_man", {4'd0, o_man}, 32'd0);
        rst_n = 1'b1; i_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {30'd0, o_valid, o_ready}, 32'b01);
        repeat (4) @(negedge clk);
        chk("discarded_input", {30'd0, o_valid, o_ready}, 32'b01);

        // Reset while stalled in DONE.
        issue(tbl[1], lat);
        compare(lat);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        chk("reset_in_done", {o_valid, o_sign, o_exp, o_zero, o_denorm, o_inf, 20'd0}, 32'd0);
        chk("reset_in_done_man", {4'd0, o_man}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_done_reset", {30'd0, o_valid, o_ready}, 32'b01);

        // Recovery after reset.
        issue(tbl[4], lat);
        compare(lat);
        release_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
